// File: rtl/bram_frame_writer.sv
// bram_frame_writer: writes a binarized XSIZE x YSIZE frame into a 1-bit-wide
// bitmap RAM. The RAM address is {y[8:0], x[9:0]}. The block can either zero
// the whole bitmap (clear) or capture one frame from a pixel stream that is
// aligned on its start-of-frame marker. Every output is registered, so a write
// appears on the RAM port one cycle after the pixel is sampled.
module bram_frame_writer #(
  parameter int XSIZE = 640,  // pixels per line, at most 1024
  parameter int YSIZE = 480   // lines per frame, at most 512
) (
  input  logic        clk,
  input  logic        reset,            // asynchronous, active low
  input  logic        clear_start,
  input  logic        capture_start,
  input  logic        pix_valid,
  input  logic        pix_sof,
  input  logic        pix_data,
  output logic [18:0] bram_addr,
  output logic        bram_write_data,
  output logic        bram_we,
  output logic        busy,
  output logic        frame_done,
  output logic        sof_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ARM,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [9:0] X_LAST = 10'(XSIZE - 1);
  localparam logic [8:0] Y_LAST = 9'(YSIZE - 1);

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;

  logic [18:0] addr_d;
  logic        wdata_d;
  logic        we_d;
  logic        busy_d;
  logic        done_d;
  logic        sof_err_d;

  // Position and value of the write issued this cycle (if any).
  logic        do_write;
  logic [9:0]  wr_x;
  logic [8:0]  wr_y;
  logic        wr_bit;

  // Next-state logic: decide whether this cycle writes, where, and how the
  // raster position advances. A write to the last pixel ends the frame.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    addr_d    = '0;
    wdata_d   = 1'b0;
    we_d      = 1'b0;
    done_d    = 1'b0;
    sof_err_d = 1'b0;
    do_write  = 1'b0;
    wr_x      = x_q;
    wr_y      = y_q;
    wr_bit    = 1'b0;

    case (state_q)
      S_IDLE: begin
        x_d = '0;
        y_d = '0;
        // Clear wins over a simultaneous capture request, which is dropped.
        if (clear_start) begin
          state_d = S_CLEAR;
        end else if (capture_start) begin
          state_d = S_ARM;
        end
      end
      S_CLEAR: begin
        do_write = 1'b1;
      end
      S_ARM: begin
        // Everything before the first start-of-frame pixel is discarded.
        if (pix_valid && pix_sof) begin
          do_write = 1'b1;
          wr_x     = '0;
          wr_y     = '0;
          wr_bit   = pix_data;
          state_d  = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (pix_valid) begin
          do_write = 1'b1;
          wr_bit   = pix_data;
          // A start-of-frame mid-frame resynchronises the raster to (0,0).
          if (pix_sof) begin
            wr_x      = '0;
            wr_y      = '0;
            sof_err_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (do_write) begin
      we_d    = 1'b1;
      addr_d  = {wr_y, wr_x};
      wdata_d = wr_bit;
      if (wr_x == X_LAST && wr_y == Y_LAST) begin
        state_d = S_DONE;
        x_d     = '0;
        y_d     = '0;
      end else if (wr_x == X_LAST) begin
        x_d = '0;
        y_d = wr_y + 9'd1;
      end else begin
        x_d = wr_x + 10'd1;
        y_d = wr_y;
      end
    end

    // Registered busy tracks the state register it is loaded alongside.
    busy_d = (state_d != S_IDLE);
  end

  // State, raster position and registered outputs; reset clears all at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      x_q             <= '0;
      y_q             <= '0;
      bram_addr       <= '0;
      bram_write_data <= 1'b0;
      bram_we         <= 1'b0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      sof_error       <= 1'b0;
    end else begin
      state_q         <= state_d;
      x_q             <= x_d;
      y_q             <= y_d;
      bram_addr       <= addr_d;
      bram_write_data <= wdata_d;
      bram_we         <= we_d;
      busy            <= busy_d;
      frame_done      <= done_d;
      sof_error       <= sof_err_d;
    end
  end

endmodule

// File: tb/tb_bram_frame_writer.sv
// Directed bench for bram_frame_writer using a small 16 x 4 frame so a full
// clear and a full capture fit in a short run.
module tb_bram_frame_writer;

  localparam int XS = 16;
  localparam int YS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear_start = 1'b0;
  logic        capture_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_sof = 1'b0;
  logic        pix_data = 1'b0;
  logic [18:0] bram_addr;
  logic        bram_write_data;
  logic        bram_we;
  logic        busy;
  logic        frame_done;
  logic        sof_error;

  int errors = 0;
  int checks = 0;

  bram_frame_writer #(.XSIZE(XS), .YSIZE(YS)) dut (
    .clk             (clk),
    .reset           (reset),
    .clear_start     (clear_start),
    .capture_start   (capture_start),
    .pix_valid       (pix_valid),
    .pix_sof         (pix_sof),
    .pix_data        (pix_data),
    .bram_addr       (bram_addr),
    .bram_write_data (bram_write_data),
    .bram_we         (bram_we),
    .busy            (busy),
    .frame_done      (frame_done),
    .sof_error       (sof_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Address of the idx-th pixel of a frame in raster order: {y, x[9:0]}.
  function automatic logic [31:0] raster_addr(input int idx);
    return 32'((idx / XS) * 1024 + (idx % XS));
  endfunction

  // Drive one pixel at the falling edge; the write it causes is visible at
  // the next falling edge, when this task returns.
  task automatic send(input logic v, input logic s, input logic d);
    pix_valid = v;
    pix_sof   = s;
    pix_data  = d;
    @(negedge clk);
  endtask

  task automatic start(input logic clr, input logic cap);
    clear_start   = clr;
    capture_start = cap;
    @(negedge clk);
    clear_start   = 1'b0;
    capture_start = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_we"}, bram_we, 1'b0);
    check({tag, "_addr"}, bram_addr, 0);
  endtask

  initial begin
    int nw, last_c, done_c;
    logic [31:0] a_first, a_15, a_16, a_last;
    logic d;

    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    check("rst_addr", bram_addr, 0);
    check("rst_wdata", bram_write_data, 0);
    check("rst_we", bram_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_sof_err", sof_error, 0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check_quiet("idle");
    $display("txn reset: released, idle");

    // ------- clear with simultaneous capture request -------
    start(1'b1, 1'b1);
    nw = 0; last_c = -1; done_c = -1;
    a_first = '1; a_15 = '1; a_16 = '1; a_last = '1;
    for (int c = 0; c < 200 && done_c < 0; c++) begin
      @(negedge clk);
      if (bram_we) begin
        check("clr_addr", bram_addr, raster_addr(nw));
        check("clr_data", bram_write_data, 1'b0);
        check("clr_busy", busy, 1'b1);
        if (nw == 0) a_first = 32'(bram_addr);
        if (nw == 15) a_15 = 32'(bram_addr);
        if (nw == 16) a_16 = 32'(bram_addr);
        a_last = 32'(bram_addr);
        nw++;
        last_c = c;
      end
      if (frame_done) begin
        done_c = c;
        check("clr_done_we", bram_we, 1'b0);
        check("clr_done_busy", busy, 1'b0);
      end
    end
    check("clr_count", nw, XS * YS);
    check("clr_first_addr", a_first, 0);
    check("clr_addr_15", a_15, 15);
    check("clr_addr_16", a_16, 1024);
    check("clr_last_addr", a_last, 3087);
    check("clr_done_seen", (done_c >= 0), 1'b1);
    check("clr_done_timing", done_c, last_c + 1);
    $display("txn clear: writes=%0d done_cycle=%0d", nw, done_c);

    // After clear the block must be idle, not armed: SOF pixels write nothing.
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 1'b1, 1'b1);
      check_quiet("post_clr");
      check("post_clr_busy", busy, 1'b0);
    end
    send(1'b0, 1'b0, 1'b0);
    $display("txn post-clear: stayed idle");

    // ---------------- capture ----------------
    start(1'b0, 1'b1);
    check("arm_busy", busy, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 1'b0, 1'b1);
      check_quiet("arm_drop");
    end
    send(1'b1, 1'b1, 1'b1);
    check("sof_we", bram_we, 1'b1);
    check("sof_addr", bram_addr, 0);
    check("sof_data", bram_write_data, 1'b1);
    check("sof_err_arm", sof_error, 1'b0);
    $display("txn capture: first SOF written at 0x%0h", bram_addr);

    // Pixels 1..57 with idle gaps; pixel 58 sits at (10,3).
    for (int idx = 1; idx < 58; idx++) begin
      if (idx % 5 == 0) begin
        send(1'b0, 1'b0, 1'b1);
        check_quiet("gap");
      end
      d = (idx % 3 == 0);
      send(1'b1, 1'b0, d);
      check("cap_we", bram_we, 1'b1);
      check("cap_addr", bram_addr, raster_addr(idx));
      check("cap_data", bram_write_data, d);
      check("cap_done", frame_done, 1'b0);
    end
    $display("txn capture: 58 pixels written");

    // SOF mid-frame at (10,3).
    send(1'b1, 1'b1, 1'b0);
    check("mid_sof_err", sof_error, 1'b1);
    check("mid_sof_we", bram_we, 1'b1);
    check("mid_sof_addr", bram_addr, 0);
    check("mid_sof_data", bram_write_data, 1'b0);
    check("mid_sof_done", frame_done, 1'b0);
    send(1'b1, 1'b0, 1'b1);
    check("resync_addr", bram_addr, 1);
    check("resync_data", bram_write_data, 1'b1);
    check("resync_err", sof_error, 1'b0);
    check("resync_done", frame_done, 1'b0);
    $display("txn capture: mid-frame SOF resynchronised");

    // Finish the frame from pixel 2 through 63 (address 3087).
    for (int idx = 2; idx < XS * YS; idx++) begin
      d = (idx % 4 == 1);
      send(1'b1, 1'b0, d);
      check("fin_we", bram_we, 1'b1);
      check("fin_addr", bram_addr, raster_addr(idx));
      check("fin_data", bram_write_data, d);
      check("fin_done", frame_done, 1'b0);
    end
    send(1'b1, 1'b0, 1'b1);
    check("cap_frame_done", frame_done, 1'b1);
    check_quiet("cap_done_cyc");
    send(1'b1, 1'b0, 1'b1);
    check("cap_done_pulse", frame_done, 1'b0);
    check_quiet("cap_after");
    check("cap_after_busy", busy, 1'b0);
    $display("txn capture: frame complete");

    // ------------- reset mid-capture -------------
    send(1'b0, 1'b0, 1'b0);
    start(1'b0, 1'b1);
    send(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 1'b1);
    check("pre_rst_we", bram_we, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_rst_we", bram_we, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_addr", bram_addr, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_hold_we", bram_we, 1'b0);
    end
    reset = 1'b1;
    send(1'b1, 1'b1, 1'b1);
    send(1'b1, 1'b0, 1'b1);
    check_quiet("post_rst");
    check("post_rst_busy", busy, 1'b0);
    $display("txn reset mid-capture: writes stopped");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_frame_writer.md
BRAM_FRAME_WRITER -- requirements
Module: bram_frame_writer

Interface
REQ-001 Parameter XSIZE, default 640: pixels per line written; XSIZE SHALL be at most 1024.
REQ-002 Parameter YSIZE, default 480: lines per frame written; YSIZE SHALL be at most 512.
REQ-003 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 clear_start  input  1  one-cycle request to zero the whole bitmap.
REQ-006 capture_start  input  1  one-cycle request to arm and capture one frame.
REQ-007 pix_valid  input  1  a pixel is present on pix_data this cycle.
REQ-008 pix_sof  input  1  qualified by pix_valid; marks the pixel at (0,0).
REQ-009 pix_data  input  1  binarized pixel; 1 = lit.
REQ-010 bram_addr  output  19  write address {y[8:0], x[9:0]}.
REQ-011 bram_write_data  output  1  bit to store.
REQ-012 bram_we  output  1  write strobe; one write per asserted cycle.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 frame_done  output  1  one-cycle pulse when a clear or capture completes.
REQ-015 sof_error  output  1  one-cycle pulse when SOF arrives mid-frame.

Function
REQ-016 The state machine SHALL have the states IDLE, CLEAR, ARM, CAPTURE and DONE.
REQ-017 All outputs SHALL be registered.
REQ-018 IDLE + clear_start -> CLEAR with x=y=0; clear_start SHALL take priority over a simultaneous capture_start, which is dropped.
REQ-019 IDLE + capture_start -> ARM.
REQ-020 Start requests SHALL be ignored outside IDLE.
REQ-021 CLEAR SHALL issue exactly one write per cycle, with bram_write_data=0, in raster order: x increments 0..XSIZE-1, then wraps to 0 while y increments, up to y=YSIZE-1.
REQ-022 After the write to (XSIZE-1, YSIZE-1), CLEAR -> DONE.
REQ-023 ARM SHALL discard every pixel until pix_valid&&pix_sof; that pixel SHALL be written to (0,0), and the state -> CAPTURE with the next position (1,0).
REQ-024 In CAPTURE, each pix_valid cycle SHALL write pix_data at the current (x,y), then advance in raster order; cycles without pix_valid SHALL write nothing and hold position.
REQ-025 A write SHALL appear on bram_we/bram_addr/bram_write_data exactly 1 cycle after the pixel is sampled.
REQ-026 The pixel is always accepted; there is no backpressure.
REQ-027 In CAPTURE, pix_valid&&pix_sof SHALL pulse sof_error, write that pixel to (0,0) and restart the raster at (1,0); the frame is not completed.
REQ-028 After the write to (XSIZE-1, YSIZE-1), CAPTURE -> DONE; later pixels SHALL be dropped.
REQ-029 DONE SHALL last one cycle, assert frame_done for that cycle, and go to IDLE; bram_we SHALL be 0 in DONE.
REQ-030 bram_we SHALL be 0 whenever no write is issued, and bram_addr SHALL be 0 in that case.
REQ-031 Address bits x[9:0] and y[8:0] SHALL be zero-extended counters; no address outside the XSIZE x YSIZE window SHALL ever be written.

Reset
REQ-032 reset low SHALL immediately force IDLE, x=y=0, and all outputs to 0 (bram_addr=0, bram_write_data=0, bram_we=0, busy=0, frame_done=0, sof_error=0), including mid-CLEAR or mid-CAPTURE; no further write SHALL issue.
REQ-033 After reset is released, the block SHALL wait in IDLE for a new request.

Verification
REQ-034 Assert reset for 3 cycles, then release -> all outputs 0, busy=0.
REQ-035 clear_start pulse in IDLE -> 307200 consecutive writes of 0; first address 0, address 639 followed by 1024, last address 491135; frame_done pulses the cycle after the last write; busy high throughout.
REQ-036 capture_start, then 5 valid pixels without SOF, then an SOF pixel with data 1 -> the 5 pixels are not written; write addr 0 data 1 one cycle later; the 640th pixel goes to addr 639 and the 641st to addr 1024.
REQ-037 In CAPTURE at (10,3), an SOF pixel arrives -> sof_error pulses for 1 cycle, write to addr 0, the next pixel goes to addr 1, and frame_done is not asserted.
REQ-038 clear_start and capture_start together in IDLE -> CLEAR runs and completes, then returns to IDLE, not ARM; reset driven low mid-CAPTURE -> bram_we is 0 from that point and busy=0.
